// File: rtl/accu_avg.sv
// accu_avg -- sliding-window moving average of accumulator group sums.
//
// Keeps the most recent N = 2**WIN_LOG2 accepted sums in a shift buffer
// together with their running total, and emits one registered average
// (floor of total / N) per accepted sum once the window has filled.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset; flushes history and outputs
//   data_in    IN_W-bit group sum from the upstream accumulator
//   valid_in   data_in is valid this cycle (one sample per high cycle)
//   clear      synchronous window flush; wins over valid_in
//   valid_out  one-cycle pulse: data_out holds a new average
//   data_out   IN_W-bit windowed average (unsigned, truncated)
//   full       window currently holds N samples
//
// Handshake: valid-only, no ready. A sample is taken on every rising edge
// where valid_in=1 and clear=0. valid_out is high for exactly one cycle
// per average-producing accept, one cycle after that accept; the consumer
// must take every pulse because there is no backpressure.
module accu_avg #(
  parameter int IN_W     = 10,
  parameter int WIN_LOG2 = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] data_in,
  input  logic            valid_in,
  input  logic            clear,
  output logic            valid_out,
  output logic [IN_W-1:0] data_out,
  output logic            full
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam int TOT_W = IN_W + WIN_LOG2;

  logic [IN_W-1:0]  win [N];
  logic [CNT_W-1:0] cnt;
  logic [TOT_W-1:0] tot;

  logic             accept;
  logic             win_full;
  logic [IN_W-1:0]  oldest;
  logic [TOT_W-1:0] tot_next;
  logic [CNT_W-1:0] cnt_next;
  logic             reach_full;

  always_comb begin
    accept   = valid_in & ~clear;
    win_full = (cnt == CNT_W'(N));
    // Until the window is full the entry falling off the end was never a
    // real sample, so nothing is subtracted.
    oldest   = win_full ? win[N-1] : '0;
    // N sums of IN_W bits fit in IN_W+WIN_LOG2 bits, so this never wraps.
    tot_next = tot + TOT_W'(data_in) - TOT_W'(oldest);
    cnt_next = win_full ? cnt : cnt + CNT_W'(1);
    reach_full = (cnt_next == CNT_W'(N));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      tot       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      full      <= 1'b0;
      for (int i = 0; i < N; i++) win[i] <= '0;
    end else if (clear) begin
      // data_out deliberately keeps its last value across a flush.
      cnt       <= '0;
      tot       <= '0;
      valid_out <= 1'b0;
      full      <= 1'b0;
      for (int i = 0; i < N; i++) win[i] <= '0;
    end else begin
      valid_out <= 1'b0;
      if (accept) begin
        for (int i = N - 1; i > 0; i--) win[i] <= win[i-1];
        win[0] <= data_in;
        tot    <= tot_next;
        cnt    <= cnt_next;
        full   <= reach_full;
        if (reach_full) begin
          data_out  <= IN_W'(tot_next >> WIN_LOG2);
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_accu_avg.sv
module tb_accu_avg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Window of 4 instance
  logic       valid_in, clear, valid_out, full;
  logic [9:0] data_in, data_out;
  // Window of 1 (pass-through) instance
  logic       valid_in0, clear0, valid_out0, full0;
  logic [9:0] data_in0, data_out0;

  accu_avg #(.IN_W(10), .WIN_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .clear(clear), .valid_out(valid_out), .data_out(data_out), .full(full)
  );

  accu_avg #(.IN_W(10), .WIN_LOG2(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in0), .valid_in(valid_in0),
    .clear(clear0), .valid_out(valid_out0), .data_out(data_out0), .full(full0)
  );

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  logic [9:0] exp0_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitors: pop and compare whenever a DUT presents a result.
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid_out data_out=%0d expected=none", data_out);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL data_out actual=%0d expected=%0d", data_out, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (valid_out0 === 1'b1) begin
      checks++;
      if (exp0_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid_out0 data_out=%0d expected=none", data_out0);
      end else begin
        logic [9:0] e;
        e = exp0_q.pop_front();
        if (data_out0 !== e) begin
          failures++;
          $display("FAIL data_out0 actual=%0d expected=%0d", data_out0, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic acc(input logic [9:0] d, input logic exp_v, input logic [9:0] exp_d);
    valid_in = 1'b1;
    clear    = 1'b0;
    data_in  = d;
    if (exp_v) exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    check("valid_out_after_accept", valid_out, exp_v);
  endtask

  task automatic do_clear(input logic with_valid, input logic [9:0] d);
    valid_in = with_valid;
    clear    = 1'b1;
    data_in  = d;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    clear    = 1'b0;
    check("valid_out_after_clear", valid_out, 0);
    check("full_after_clear", full, 0);
  endtask

  task automatic acc0(input logic [9:0] d, input logic [9:0] exp_d);
    valid_in0 = 1'b1;
    data_in0  = d;
    exp0_q.push_back(exp_d);
    @(posedge clk);
    #1;
    valid_in0 = 1'b0;
    check("valid_out0_after_accept", valid_out0, 1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; clear = 1'b0; data_in = '0;
    valid_in0 = 1'b0; clear0 = 1'b0; data_in0 = '0;
    idle(2);
    check("reset_data_out", data_out, 0);
    check("reset_valid_out", valid_out, 0);
    check("reset_full", full, 0);
    check("reset_data_out0", data_out0, 0);
    rst_n = 1'b1;
    idle(1);

    // Fill and steady state, spaced pulses
    acc(10'd20, 0, 0);  idle(1);
    acc(10'd114, 0, 0); idle(1);
    acc(10'd68, 0, 0);  idle(1);
    check("fill_full", full, 0);
    check("fill_data_out", data_out, 0);
    acc(10'd10, 1, 10'd53);
    check("full_rises_with_first_output", full, 1);
    idle(1);
    check("first_avg_data_out", data_out, 53);
    acc(10'd30, 1, 10'd55); idle(1);
    check("steady_data_out", data_out, 55);

    // Clear together with a valid sample: sample dropped, data_out held
    do_clear(1'b1, 10'd500);
    idle(1);
    check("clear_holds_data_out", data_out, 55);
    acc(10'd4, 0, 0); idle(1);
    acc(10'd4, 0, 0); idle(1);
    acc(10'd4, 0, 0); idle(1);
    acc(10'd8, 1, 10'd5); idle(1);
    check("refill_data_out", data_out, 5);
    check("refill_full", full, 1);

    // Idle gaps do not age the window: history [8,4,4,4]
    idle(5);
    check("idle_data_out_stable", data_out, 5);
    check("idle_full_stable", full, 1);
    acc(10'd12, 1, 10'd7); idle(1);   // 20 + 12 - 4 = 28 -> 7

    // Saturation: five back-to-back maxima from an empty window
    do_clear(1'b0, 10'd0);
    acc(10'd1020, 0, 0);
    acc(10'd1020, 0, 0);
    acc(10'd1020, 0, 0);
    acc(10'd1020, 1, 10'd1020);
    acc(10'd1020, 1, 10'd1020);
    idle(1);
    check("saturation_data_out", data_out, 1020);

    // Reset mid-fill discards history
    do_clear(1'b0, 10'd0);
    acc(10'd100, 0, 0);
    acc(10'd200, 0, 0);
    rst_n = 1'b0;
    idle(1);
    check("midfill_reset_data_out", data_out, 0);
    check("midfill_reset_valid_out", valid_out, 0);
    check("midfill_reset_full", full, 0);
    rst_n = 1'b1;
    acc(10'd8, 0, 0);
    acc(10'd8, 0, 0);
    acc(10'd8, 0, 0);
    acc(10'd8, 1, 10'd8);
    idle(1);
    check("post_reset_data_out", data_out, 8);

    // Pass-through window of one
    acc0(10'd7, 10'd7);
    check("w0_full", full0, 1);
    acc0(10'd9, 10'd9);
    idle(1);
    check("w0_data_out", data_out0, 9);

    idle(2);
    check("pending_expected", exp_q.size(), 0);
    check("pending_expected0", exp0_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accu_avg.md
# accu_avg

Moving-average stage sitting directly downstream of the 4-sample accumulator. It consumes each 10-bit group sum the accumulator emits on its single-cycle valid pulse. It averages the most recent 2^WIN_LOG2 sums over a sliding window and emits one registered average per accepted sum once the window is full. A synchronous `clear` lets control logic restart the window without a global reset.

## Interface
- `IN_W`, 10, width of incoming sums and of the output average.
- `WIN_LOG2`, 2, log2 of window length N (legal 0..3; N = 1, 2, 4, 8).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `data_in`  in  IN_W  group sum from the accumulator.
- `valid_in`  in  1  `data_in` valid this cycle; single- or multi-cycle pulses are each one sample per cycle.
- `clear`  in  1  synchronous window flush, active-high.
- `valid_out`  out  1  one-cycle pulse; `data_out` holds a new average.
- `data_out`  out  IN_W  windowed average, unsigned, truncated.
- `full`  out  1  window holds N samples.

## Operation
- State:
  - N-entry shift buffer `win[0..N-1]` of IN_W bits.
  - Fill counter `cnt` (0..N, saturating at N).
  - Running total `tot` of IN_W+WIN_LOG2 bits; it cannot overflow.
- Accept happens when `valid_in`=1 and `clear`=0:
  - `win` shifts, and `data_in` enters `win[0]`.
  - `oldest` is `win[N-1]` if `cnt`==N, else 0.
  - `tot_next = tot + data_in - oldest`.
  - `cnt` increments while below N.
- Output:
  - The accept that makes `cnt` reach N, and every accept thereafter, registers `data_out = tot_next >> WIN_LOG2` (floor).
  - The same accept sets `valid_out`=1 for the following cycle.
  - Accepts during fill (`cnt_next` < N) produce no `valid_out`, and `data_out` is unchanged.
- `full` = (`cnt`==N), registered.
- `clear`=1:
  - `cnt`, `tot` and all `win` entries go to 0; `full` goes to 0.
  - `data_out` holds its last value; `valid_out` is 0 next cycle.
  - `clear` has priority over `valid_in` in the same cycle; that sample is discarded.
- WIN_LOG2=0: pass-through with one register stage; the first accept already produces an output.
- No backpressure. The downstream consumer must accept every `valid_out` pulse.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - `data_out`=0, `valid_out`=0, `full`=0.
  - `cnt`=0, `tot`=0, all `win`=0.
  - Reset asserted mid-fill or mid-stream discards all history. The first N accepts after release refill the window.
- Latency: one cycle from accepting edge to `valid_out`/`data_out`.
- Throughput: one sample per cycle; back-to-back `valid_in` yields back-to-back `valid_out` once full.
- `valid_out` is never high for two cycles from one accept. With `valid_in` low it is 0.
- `full` rises in the same cycle as the first `valid_out`.
- Gaps in `valid_in` do not age the window; only accepts shift it.

## Test plan
- Fill and steady state (WIN_LOG2=2):
  - Sums 20, 114, 68, 10 on spaced single-cycle pulses → no `valid_out` for the first three.
  - After the 4th, `data_out`=53 (212>>2) with a 1-cycle `valid_out`; `full`=1.
  - Then 30 → `data_out`=55 (222>>2).
- Saturation: five back-to-back sums of 1020 → `valid_out` high on the 4th and 5th result cycles, `data_out`=1020 both times; no overflow.
- Clear mid-stream:
  - After the window is full, assert `clear` together with `valid_in` (data 500) → sample dropped, `full`=0, `data_out` holds 55.
  - Refill with 4,4,4,8 → `data_out`=5.
- Reset mid-fill: two accepts (100, 200), then `rst_n`=0 for one cycle → all outputs 0; the next four accepts of 8 → `data_out`=8 only on the 4th.
- Idle gaps: with the window full, `valid_in` low for 5 cycles → `valid_out` stays 0 and `data_out` is stable; the next accept uses the unchanged history.
- WIN_LOG2=0: accepts 7, 9 → `data_out` 7 then 9, each one cycle after its input with a `valid_out` pulse.
